// File: rtl/pu_cycle_sync_pkg.sv
// Shared definitions for the IO-to-control-unit cycle synchroniser.
// State encoding and default parameter values used across the block.
package pu_cycle_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } state_t;

    localparam int DEF_IO_COUNT  = 2;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/pu_cycle_sync_watchdog.sv
// Collection-window watchdog: counts window clocks, saturating at TIMEOUT.
// expired flags the clock on which the count reaches (or sits at) TIMEOUT.
module pu_cycle_sync_watchdog #(
    parameter int TIMEOUT       = 1024,
    parameter int TIMEOUT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] LAST  = TIMEOUT_WIDTH'(TIMEOUT - 1);

    logic [TIMEOUT_WIDTH-1:0] count;

    // Window clock counter; clear wins over run, holds at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Asserted when this clock brings the count to TIMEOUT.
    assign expired = run && (count >= LAST);

endmodule

// File: rtl/pu_cycle_sync.sv
// Rendezvous generator for the microcode control unit.
// Optional macro PU_CYCLE_SYNC_FORCE_EN: watchdog expiry forces READY.
module pu_cycle_sync
    import pu_cycle_sync_pkg::*;
#(
    parameter int IO_COUNT      = DEF_IO_COUNT,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int TIMEOUT_WIDTH = $clog2(TIMEOUT + 1),
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [IO_COUNT-1:0]  io_ready,
    input  logic [IO_COUNT-1:0]  io_mask,
    input  logic                 cycle,
    output logic                 rendezvous,
    output logic [IO_COUNT-1:0]  pending,
    output logic                 waiting,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 timeout
);

    state_t              state;
    logic                cycle_d;
    logic                cycle_rise;
    logic                all_done;
    logic                force_ready;
    logic [IO_COUNT-1:0] masked;
    logic                wd_clr;
    logic                wd_run;
    logic                wd_expired;

    assign cycle_rise = cycle & ~cycle_d;
    assign masked     = io_ready & io_mask;
    assign all_done   = ((pending | io_ready) & io_mask) == io_mask;

    // Watchdog only runs on a COLLECT clock that does not open a new window.
    assign wd_clr = ~enable | (cycle_rise & (state != IDLE));
    assign wd_run = enable & (state == COLLECT) & ~cycle_rise;

`ifdef PU_CYCLE_SYNC_FORCE_EN
    assign force_ready = wd_expired;
`else
    assign force_ready = 1'b0;
`endif

    pu_cycle_sync_watchdog #(
        .TIMEOUT       (TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .run     (wd_run),
        .expired (wd_expired)
    );

    // Window FSM with registered outputs; disable beats cycle rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cycle_d     <= 1'b0;
            rendezvous  <= 1'b0;
            pending     <= '0;
            waiting     <= 1'b0;
            cycle_count <= '0;
            timeout     <= 1'b0;
        end else begin
            cycle_d <= cycle;
            if (!enable) begin
                state      <= IDLE;
                rendezvous <= 1'b0;
                pending    <= '0;
                waiting    <= 1'b0;
                timeout    <= 1'b0;
            end else if (cycle_rise && (state != IDLE)) begin
                state       <= COLLECT;
                waiting     <= 1'b1;
                rendezvous  <= 1'b0;
                pending     <= masked;
                cycle_count <= cycle_count + 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        state      <= COLLECT;
                        waiting    <= 1'b1;
                        rendezvous <= 1'b0;
                    end
                    COLLECT: begin
                        pending <= pending | masked;
                        if (wd_expired) begin
                            timeout <= 1'b1;
                        end
                        if (all_done || force_ready) begin
                            state      <= READY;
                            waiting    <= 1'b0;
                            rendezvous <= 1'b1;
                        end
                    end
                    READY: begin
                        rendezvous <= 1'b1;
                        waiting    <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        rendezvous <= 1'b0;
                        waiting    <= 1'b0;
                        pending    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pu_cycle_sync.sv
// Directed bench for pu_cycle_sync (IO_COUNT=2, TIMEOUT=8, CNT_WIDTH=2).
// Expected values are hand-derived for each step.
module tb_pu_cycle_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] io_ready;
    logic [1:0] io_mask;
    logic       cycle;
    logic       rendezvous;
    logic [1:0] pending;
    logic       waiting;
    logic [1:0] cycle_count;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pu_cycle_sync #(
        .IO_COUNT  (2),
        .TIMEOUT   (8),
        .CNT_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .io_ready    (io_ready),
        .io_mask     (io_mask),
        .cycle       (cycle),
        .rendezvous  (rendezvous),
        .pending     (pending),
        .waiting     (waiting),
        .cycle_count (cycle_count),
        .timeout     (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_cycle();
        cycle = 1'b1;
        step();
        cycle = 1'b0;
        step();
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        io_ready = 2'b00;
        io_mask  = 2'b11;
        cycle    = 1'b0;
        step();
        step();
        chk("rst_rdv", 32'(rendezvous), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_wait", 32'(waiting), 0);
        chk("rst_cnt", 32'(cycle_count), 0);
        chk("rst_tmo", 32'(timeout), 0);
        rst = 1'b0;

        // Readies in different clocks
        enable = 1'b1;
        step();
        chk("enter_wait", 32'(waiting), 1);
        step();
        step();
        io_ready = 2'b01;
        step();
        io_ready = 2'b00;
        chk("t1_pend01", 32'(pending), 2'b01);
        chk("t1_rdv0", 32'(rendezvous), 0);
        step();
        step();
        step();
        io_ready = 2'b10;
        step();
        io_ready = 2'b00;
        chk("t1_rdv1", 32'(rendezvous), 1);
        chk("t1_pend11", 32'(pending), 2'b11);
        chk("t1_wait0", 32'(waiting), 0);
        chk("t1_tmo0", 32'(timeout), 0);
        step();
        step();
        chk("t1_hold", 32'(rendezvous), 1);
        io_ready = 2'b01;
        step();
        io_ready = 2'b00;
        chk("t1_ign", 32'(pending), 2'b11);

        // Cycle rise; held high three clocks counts once
        cycle = 1'b1;
        step();
        chk("rise_cnt", 32'(cycle_count), 1);
        chk("rise_rdv", 32'(rendezvous), 0);
        chk("rise_pend", 32'(pending), 0);
        chk("rise_wait", 32'(waiting), 1);
        step();
        step();
        chk("held_cnt", 32'(cycle_count), 1);
        cycle = 1'b0;
        step();
        io_ready = 2'b11;
        step();
        io_ready = 2'b00;
        chk("both_rdv", 32'(rendezvous), 1);
        step();

        // Ready pulse coincident with cycle rise
        cycle    = 1'b1;
        io_ready = 2'b10;
        step();
        cycle    = 1'b0;
        io_ready = 2'b00;
        chk("coin_pend", 32'(pending), 2'b10);
        chk("coin_cnt", 32'(cycle_count), 2);
        chk("coin_rdv", 32'(rendezvous), 0);
        step();
        chk("coin_rdv_b", 32'(rendezvous), 0);
        io_ready = 2'b01;
        step();
        io_ready = 2'b00;
        chk("coin_rdv1", 32'(rendezvous), 1);
        chk("coin_pend11", 32'(pending), 2'b11);

        // Counter wrap, including rises while collecting
        pulse_cycle();
        chk("wrap_3", 32'(cycle_count), 3);
        pulse_cycle();
        chk("wrap_0", 32'(cycle_count), 0);
        pulse_cycle();
        chk("wrap_1", 32'(cycle_count), 1);
        chk("wrap_wait", 32'(waiting), 1);

        // Timeout: only io_ready[0] arrives
        io_ready = 2'b01;
        step();
        io_ready = 2'b00;
        step();
        step();
        step();
        step();
        step();
        chk("tmo_pre", 32'(timeout), 0);
        chk("tmo_pre_rdv", 32'(rendezvous), 0);
        step();
        chk("tmo_set", 32'(timeout), 1);
        chk("tmo_pend", 32'(pending), 2'b01);
`ifdef PU_CYCLE_SYNC_FORCE_EN
        chk("tmo_force_rdv", 32'(rendezvous), 1);
        chk("tmo_force_wait", 32'(waiting), 0);
`else
        chk("tmo_rdv", 32'(rendezvous), 0);
        chk("tmo_wait", 32'(waiting), 1);
`endif
        step();
        step();
        chk("tmo_sticky", 32'(timeout), 1);
`ifndef PU_CYCLE_SYNC_FORCE_EN
        chk("tmo_rdv_stay", 32'(rendezvous), 0);
`endif

        // Disable mid-window
        enable = 1'b0;
        step();
        chk("dis_pend", 32'(pending), 0);
        chk("dis_tmo", 32'(timeout), 0);
        chk("dis_wait", 32'(waiting), 0);
        chk("dis_rdv", 32'(rendezvous), 0);
        chk("dis_cnt", 32'(cycle_count), 1);

        // Empty mask
        io_mask = 2'b00;
        enable  = 1'b1;
        step();
        chk("em_enter", 32'(rendezvous), 0);
        step();
        chk("em_rdv1", 32'(rendezvous), 1);
        cycle = 1'b1;
        step();
        cycle = 1'b0;
        chk("em_cnt", 32'(cycle_count), 2);
        chk("em_rdv0", 32'(rendezvous), 0);
        step();
        chk("em_rdv1b", 32'(rendezvous), 1);

        // Asynchronous reset while in READY
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rdv", 32'(rendezvous), 0);
        chk("ar_cnt", 32'(cycle_count), 0);
        chk("ar_wait", 32'(waiting), 0);
        chk("ar_pend", 32'(pending), 0);
        chk("ar_tmo", 32'(timeout), 0);
        step();
        rst = 1'b0;
        step();
        chk("ar_restart", 32'(waiting), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pu_cycle_sync.md
Name: pu_cycle_sync

Overview:
- Upstream neighbour of the microcode control unit.
- Generates the control unit's `rendezvous` input once every participating IO processing unit reports its per-cycle transfer done.
- Observes the control unit's `cycle` output to start each new collection window.
- Counts completed computational cycles and raises a sticky watchdog flag when an IO unit stalls a window too long.

Parameters:
- IO_COUNT, 2: number of IO units with ready inputs.
- TIMEOUT, 1024: clocks a collection window may last before the timeout flag sets.
- TIMEOUT_WIDTH, $clog2(TIMEOUT+1): watchdog counter width.
- CNT_WIDTH, 16: cycle counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  synchronisation run enable
- io_ready  in  IO_COUNT  per-IO single-clock done pulse
- io_mask  in  IO_COUNT  1 = IO participates; static while enable is high
- cycle  in  1  control unit's cycle output, high while pc==1
- rendezvous  out  1  to control unit; registered
- pending  out  IO_COUNT  latched ready bits of the current window
- waiting  out  1  high in COLLECT
- cycle_count  out  CNT_WIDTH  completed cycles
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values (asynchronous assertion): state IDLE; rendezvous 0; pending 0; waiting 0; cycle_count 0; timeout 0; watchdog 0; cycle_d 0.
- cycle_rise = cycle & ~cycle_d, where cycle_d is cycle registered.
- all_done = ((pending | io_ready) & io_mask) == io_mask.
- IDLE:
  - rendezvous = 0.
  - enable = 1 → COLLECT next clock.
- COLLECT:
  - waiting = 1.
  - pending <= pending | (io_ready & io_mask).
  - watchdog increments, saturating at TIMEOUT.
  - all_done → READY next clock, with rendezvous = 1 in that same clock; a ready pulse arriving in this clock counts (1-clock latency).
  - io_mask == 0 → READY on the first COLLECT clock.
  - watchdog reaches TIMEOUT → timeout <= 1; state stays COLLECT (see Optional Feature).
- READY:
  - rendezvous held high until cycle_rise.
  - Further io_ready pulses are ignored.
- cycle_rise in READY or COLLECT:
  - pending <= io_ready & io_mask, so a pulse coincident with the rise belongs to the new window.
  - watchdog <= 0; rendezvous <= 0; state COLLECT.
  - cycle_count <= cycle_count + 1, wrapping modulo 2^CNT_WIDTH.
- A cycle_rise while in COLLECT (control restarted without rendezvous) is treated identically and still counted.
- enable falling in any state → IDLE next clock; pending, watchdog and timeout cleared; rendezvous 0; cycle_count kept.
- cycle held high for several clocks counts once.
- Reset mid-window aborts immediately; no partial state survives.

Optional Feature:
- Macro: PU_CYCLE_SYNC_FORCE_EN.
- Defined: when the watchdog reaches TIMEOUT in COLLECT, timeout sets and the state is forced to READY (rendezvous = 1 next clock) even with missing readies. pending still shows which IOs were missing, until the next cycle_rise.
- Undefined: timeout only flags; the block keeps waiting in COLLECT indefinitely.

Decomposition:
- Shared package/include: state encoding constants IDLE=2'd0, COLLECT=2'd1, READY=2'd2; cycle-sync default parameter constants.
- Watchdog counter sits naturally in sub-module pu_cycle_sync_watchdog:
  - inputs: clr, run
  - outputs: expired
  - parameters: TIMEOUT, TIMEOUT_WIDTH
- Everything else stays in a single FSM.

Test Plan:
- Readies in different clocks: IO_COUNT=2, mask=2'b11, enable=1; io_ready[0] at t=3, io_ready[1] at t=7 → rendezvous rises at t=8, pending=2'b11, held until cycle pulse; cycle_count 0→1.
- Empty mask: mask=2'b00 → rendezvous=1 one clock after entering COLLECT, every window.
- Coincident pulse: io_ready[1] in the same clock as cycle_rise → new window pending=2'b10, then rendezvous follows io_ready[0] alone.
- Timeout: TIMEOUT=8, only io_ready[0] → timeout=1 after 8 COLLECT clocks.
  - Macro undefined: rendezvous stays 0.
  - PU_CYCLE_SYNC_FORCE_EN defined: rendezvous=1 next clock, pending=2'b01.
- Counter wrap: CNT_WIDTH=2, 5 cycle pulses → cycle_count=1; cycle held high 3 clocks increments once.
- Reset and disable: assert rst asynchronously in READY → all outputs 0 immediately; drop enable in COLLECT → IDLE, pending=0, timeout=0, cycle_count retained.
